// File: rtl/gyro_pkg.sv
// Shared types and constants for the gyro sample scheduler.
// Holds the FSM state encoding, the signed axis sample type, the gyro
// register addresses and the 16-bit saturation limits.
package gyro_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] axis_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_X = 3'd1,
        RD_Y = 3'd2,
        RD_Z = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam logic [7:0] REG_GYRO_X = 8'h43;
    localparam logic [7:0] REG_GYRO_Y = 8'h45;
    localparam logic [7:0] REG_GYRO_Z = 8'h47;

    localparam axis_t SAT16_MAX = 16'sh7FFF;
    localparam axis_t SAT16_MIN = 16'sh8000;

endpackage

// File: rtl/gyro_period_timer.sv
// Free-running sample period counter with a one-cycle tick.
// Counts 0..SAMPLE_PERIOD-1 while enabled; tick is high on the last count,
// after which the counter wraps. Disabling holds the counter at zero.
module gyro_period_timer #(
    parameter int SAMPLE_PERIOD = 100000
) (
    input  logic clk_100mhz,
    input  logic rst_in_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

    logic [CW-1:0] count;

    // period counter: wraps on the last count, parked at zero while disabled
    always_ff @(posedge clk_100mhz) begin
        if (!rst_in_n) begin
            count <= '0;
        end else if (!enable || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/gyro_sample_scheduler.sv
// Gyro sample scheduler: on each period tick reads X, Y and Z from the
// register-read bus, then presents all three axes together with a one-cycle
// valid. Handles per-read timeout recovery and counts ticks lost while busy.
// Optional build macro GYRO_BIAS_CAL_EN: average the first 2^CAL_LOG2
// samples as a per-axis bias and subtract it (saturated) from later samples.
module gyro_sample_scheduler
    import gyro_pkg::*;
#(
    parameter int         SAMPLE_PERIOD = 100000,
    parameter int         TIMEOUT       = 1023,
    parameter logic [7:0] ADDR_X        = REG_GYRO_X,
    parameter logic [7:0] ADDR_Y        = REG_GYRO_Y,
    parameter logic [7:0] ADDR_Z        = REG_GYRO_Z,
    parameter int         CAL_LOG2      = 6
) (
    input  logic        clk_100mhz,
    input  logic        rst_in_n,
    input  logic        enable_in,
    output logic        rd_req_out,
    output logic [7:0]  rd_addr_out,
    input  logic        rd_ack_in,
    input  logic [15:0] rd_data_in,
    output logic [15:0] gx_out,
    output logic [15:0] gy_out,
    output logic [15:0] gz_out,
    output logic        sample_valid_out,
    output logic        busy_out,
    output logic [7:0]  overrun_cnt_out,
    output logic        timeout_err_out,
    output logic        cal_done_out
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic          tick;
    logic          in_rd, accept, tmo;
    logic          req;
    logic [7:0]    addr;
    logic [TW-1:0] tcnt;
    axis_t         x_p0, y_p0, z_in;
    axis_t         gx_p1, gy_p1, gz_p1;
    logic          vld_p1;
    logic [7:0]    ovr;
    logic          terr;

    assign z_in = rd_data_in;

    gyro_period_timer #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_timer (
        .clk_100mhz(clk_100mhz),
        .rst_in_n  (rst_in_n),
        .enable    (enable_in),
        .tick      (tick)
    );

    // state register
    always_ff @(posedge clk_100mhz) begin
        if (!rst_in_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state plus read handshake decode; an ack on the timeout cycle wins
    always_comb begin
        state_nxt = state;
        in_rd     = (state == RD_X) || (state == RD_Y) || (state == RD_Z);
        accept    = in_rd && req && rd_ack_in;
        tmo       = in_rd && req && !rd_ack_in && (tcnt == TLAST);
        case (state)
            IDLE: if (tick) state_nxt = RD_X;
            RD_X: if (accept) state_nxt = RD_Y; else if (tmo) state_nxt = IDLE;
            RD_Y: if (accept) state_nxt = RD_Z; else if (tmo) state_nxt = IDLE;
            RD_Z: if (accept) state_nxt = OUT;  else if (tmo) state_nxt = IDLE;
            OUT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // bus request, address and per-read wait counter; request idles one
    // cycle after every ack so consecutive reads are always separated
    always_ff @(posedge clk_100mhz) begin
        if (!rst_in_n) begin
            req  <= 1'b0;
            addr <= '0;
            tcnt <= '0;
        end else if ((state == IDLE) && tick) begin
            req  <= 1'b1;
            addr <= ADDR_X;
            tcnt <= '0;
        end else if (accept) begin
            req  <= 1'b0;
            tcnt <= '0;
            if (state == RD_X) addr <= ADDR_Y;
            else if (state == RD_Y) addr <= ADDR_Z;
        end else if (tmo) begin
            req  <= 1'b0;
            tcnt <= '0;
        end else if (in_rd && !req) begin
            req <= 1'b1;
        end else if (in_rd) begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // stage 0: X and Y staging, discarded when a read times out
    always_ff @(posedge clk_100mhz) begin
        if (!rst_in_n) begin
            x_p0 <= '0;
            y_p0 <= '0;
        end else if (tmo) begin
            x_p0 <= '0;
            y_p0 <= '0;
        end else if (accept && (state == RD_X)) begin
            x_p0 <= rd_data_in;
        end else if (accept && (state == RD_Y)) begin
            y_p0 <= rd_data_in;
        end
    end

`ifdef GYRO_BIAS_CAL_EN
    localparam int ACC_W = DATA_W + CAL_LOG2;
    localparam logic signed [DATA_W:0] HI17 = 17'sd32767;
    localparam logic signed [DATA_W:0] LO17 = -17'sd32768;

    logic signed [ACC_W-1:0] acc_x, acc_y, acc_z;
    logic [CAL_LOG2-1:0]     cal_cnt;
    logic                    cal_done;
    axis_t                   bias_x, bias_y, bias_z;

    function automatic axis_t sat16(input logic signed [DATA_W:0] v);
        if (v > HI17) return SAT16_MAX;
        if (v < LO17) return SAT16_MIN;
        return axis_t'(v);
    endfunction

    assign bias_x = axis_t'(acc_x >>> CAL_LOG2);
    assign bias_y = axis_t'(acc_y >>> CAL_LOG2);
    assign bias_z = axis_t'(acc_z >>> CAL_LOG2);

    // bias accumulation over the first complete samples after reset
    always_ff @(posedge clk_100mhz) begin
        if (!rst_in_n) begin
            acc_x    <= '0;
            acc_y    <= '0;
            acc_z    <= '0;
            cal_cnt  <= '0;
            cal_done <= 1'b0;
        end else if (accept && (state == RD_Z) && !cal_done) begin
            acc_x   <= acc_x + ACC_W'(x_p0);
            acc_y   <= acc_y + ACC_W'(y_p0);
            acc_z   <= acc_z + ACC_W'(z_in);
            cal_cnt <= cal_cnt + CAL_LOG2'(1);
            if (cal_cnt == '1) cal_done <= 1'b1;
        end
    end

    assign cal_done_out = cal_done;
`else
    // calibration absent: always ready; CAL_LOG2 only shapes the calibrating build
    localparam logic CAL_READY = (CAL_LOG2 >= 0);
    assign cal_done_out = CAL_READY;
`endif

    // stage 1: all three axes land together on the Z ack edge
    always_ff @(posedge clk_100mhz) begin
        if (!rst_in_n) begin
            gx_p1  <= '0;
            gy_p1  <= '0;
            gz_p1  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (accept && (state == RD_Z)) begin
`ifdef GYRO_BIAS_CAL_EN
                if (cal_done) begin
                    gx_p1  <= sat16(17'(x_p0) - 17'(bias_x));
                    gy_p1  <= sat16(17'(y_p0) - 17'(bias_y));
                    gz_p1  <= sat16(17'(z_in) - 17'(bias_z));
                    vld_p1 <= 1'b1;
                end
`else
                gx_p1  <= x_p0;
                gy_p1  <= y_p0;
                gz_p1  <= z_in;
                vld_p1 <= 1'b1;
`endif
            end
        end
    end

    // overrun accounting and sticky timeout flag
    always_ff @(posedge clk_100mhz) begin
        if (!rst_in_n) begin
            ovr  <= '0;
            terr <= 1'b0;
        end else begin
            if (tick && (state != IDLE) && (ovr != 8'hFF)) ovr <= ovr + 8'd1;
            if (tmo) terr <= 1'b1;
        end
    end

    assign rd_req_out       = req;
    assign rd_addr_out      = addr;
    assign gx_out           = gx_p1;
    assign gy_out           = gy_p1;
    assign gz_out           = gz_p1;
    assign sample_valid_out = vld_p1;
    assign busy_out         = (state != IDLE);
    assign overrun_cnt_out  = ovr;
    assign timeout_err_out  = terr;

endmodule

// File: tb/tb_gyro_sample_scheduler.sv
// Scoreboard bench for gyro_sample_scheduler (default build).
// dut: SAMPLE_PERIOD=100, TIMEOUT=15 -- reset, sampling, timeout, ack races.
// dut2: SAMPLE_PERIOD=10, 20-cycle bus -- overrun counting and saturation.
module tb_gyro_sample_scheduler;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               rd_req, rd_ack;
    logic [7:0]         rd_addr;
    logic [15:0]        rd_data;
    logic signed [15:0] gx, gy, gz;
    logic               valid, busy, terr, cal_done;
    logic [7:0]         ovr;

    logic               en2, rd_req2, rd_ack2;
    logic [7:0]         rd_addr2;
    logic [15:0]        rd_data2;
    logic signed [15:0] gx2, gy2, gz2;
    logic               valid2, busy2, terr2, cal_done2;
    logic [7:0]         ovr2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit dut2_done = 0;

    typedef struct {
        int x;
        int y;
        int z;
        int c;
    } exp_t;
    exp_t q[$];

    gyro_sample_scheduler #(.SAMPLE_PERIOD(100), .TIMEOUT(15)) dut (
        .clk_100mhz(clk), .rst_in_n(rst_n), .enable_in(en),
        .rd_req_out(rd_req), .rd_addr_out(rd_addr),
        .rd_ack_in(rd_ack), .rd_data_in(rd_data),
        .gx_out(gx), .gy_out(gy), .gz_out(gz),
        .sample_valid_out(valid), .busy_out(busy),
        .overrun_cnt_out(ovr), .timeout_err_out(terr), .cal_done_out(cal_done)
    );

    gyro_sample_scheduler #(.SAMPLE_PERIOD(10), .TIMEOUT(63)) dut2 (
        .clk_100mhz(clk), .rst_in_n(rst_n), .enable_in(en2),
        .rd_req_out(rd_req2), .rd_addr_out(rd_addr2),
        .rd_ack_in(rd_ack2), .rd_data_in(rd_data2),
        .gx_out(gx2), .gy_out(gy2), .gz_out(gz2),
        .sample_valid_out(valid2), .busy_out(busy2),
        .overrun_cnt_out(ovr2), .timeout_err_out(terr2), .cal_done_out(cal_done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: every valid pulse must match the oldest expected sample
    initial forever begin
        @(negedge clk);
        if (valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_valid: got valid with gx=%0d, expected none", gx);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("gx", gx, e.x);
                chk("gy", gy, e.y);
                chk("gz", gz, e.z);
                chk("valid_cycle", cyc, e.c);
            end
        end
    end

    // serve one read: wait for request, check address, ack after dly cycles
    task automatic serve(input logic [7:0] a, input logic [15:0] d, input int dly,
                         input bit push, input int ex, input int ey, input int ez);
        int w = 0;
        exp_t e;
        while (!rd_req && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!rd_req) begin
            chk("req_wait", 0, 1);
            return;
        end
        chk("rd_addr", rd_addr, a);
        repeat (dly) @(negedge clk);
        rd_data = d;
        rd_ack  = 1'b1;
        if (push) begin
            e.x = ex; e.y = ey; e.z = ez; e.c = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk);
        rd_ack  = 1'b0;
        rd_data = '0;
        chk("req_drop", rd_req, 0);
    endtask

    // dut2 bus: acks every read 20 cycles after the request, data = address
    initial begin
        int d2 = 0;
        rd_ack2  = 1'b0;
        rd_data2 = '0;
        en2      = 1'b1;
        forever begin
            @(negedge clk);
            if (rd_ack2) begin
                rd_ack2 = 1'b0;
            end else if (rd_req2) begin
                if (d2 == 20) begin
                    rd_ack2  = 1'b1;
                    rd_data2 = {8'h00, rd_addr2};
                    d2 = 0;
                end else begin
                    d2++;
                end
            end
        end
    end

    // dut2 checker: six ticks lost per 70-cycle sample, saturating at 255
    initial begin
        int k = 0;
        int e;
        @(posedge rst_n);
        for (int i = 0; i < 8000 && k < 45; i++) begin
            @(negedge clk);
            if (valid2) begin
                k++;
                e = (6 * k > 255) ? 255 : 6 * k;
                chk("overrun_cnt", ovr2, e);
                if (k == 1 || k == 45) begin
                    chk("gx2", gx2, 67);
                    chk("gz2", gz2, 71);
                    chk("timeout_err2", terr2, 0);
                end
            end
        end
        dut2_done = (k == 45);
    end

    initial begin
        int cnt;
        int w;
        rst_n   = 1'b0;
        en      = 1'b1;
        rd_ack  = 1'b0;
        rd_data = '0;

        // reset held three cycles with enable high
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", rd_req, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_gx", gx, 0);
        chk("rst_gy", gy, 0);
        chk("rst_gz", gz, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_terr", terr, 0);
`ifdef GYRO_BIAS_CAL_EN
        chk("rst_cal_done", cal_done, 0);
`else
        chk("rst_cal_done", cal_done, 1);
`endif
        chk("rst_req2", rd_req2, 0);
        rst_n = 1'b1;

        // first request exactly SAMPLE_PERIOD cycles after release
        cnt = 0;
        while (!rd_req && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        chk("first_req_latency", cnt, 100);

        // normal sample, 2-cycle bus delay
        serve(8'h43, 16'h0100, 2, 0, 0, 0, 0);
        serve(8'h45, 16'h0200, 2, 0, 0, 0, 0);
        serve(8'h47, 16'hF600, 2, 1, 256, 512, -2560);
        chk("terr_clean", terr, 0);

        // timeout on Y: request held 15 cycles, then abandoned
        serve(8'h43, 16'h0011, 1, 0, 0, 0, 0);
        w = 0;
        while (!rd_req && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("tmo_addr", rd_addr, 8'h45);
        cnt = 0;
        while (rd_req && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_req_len", cnt, 15);
        chk("tmo_err", terr, 1);
        chk("tmo_busy", busy, 0);

        // restart at X with boundary values
        serve(8'h43, 16'h7FFF, 1, 0, 0, 0, 0);
        serve(8'h45, 16'h8000, 1, 0, 0, 0, 0);
        serve(8'h47, 16'h0001, 1, 1, 32767, -32768, 1);
        chk("tmo_err_sticky", terr, 1);

        // ack on the timeout cycle of X is accepted
        serve(8'h43, 16'h1234, 14, 0, 0, 0, 0);
        serve(8'h45, 16'hFFFF, 0, 0, 0, 0, 0);
        serve(8'h47, 16'h0005, 0, 1, 4660, -1, 5);

        // stray ack while idle changes nothing
        w = 0;
        while (busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        rd_data = 16'hAAAA;
        rd_ack  = 1'b1;
        @(negedge clk);
        rd_ack  = 1'b0;
        rd_data = '0;
        chk("stray_busy", busy, 0);
        chk("stray_req", rd_req, 0);
        chk("stray_gx_hold", gx, 4660);

        // enable drops mid-sample: sample completes, no further ticks
        serve(8'h43, 16'h0003, 1, 0, 0, 0, 0);
        en = 1'b0;
        serve(8'h45, 16'hFFFD, 1, 0, 0, 0, 0);
        serve(8'h47, 16'h8000, 1, 1, 3, -3, -32768);
        cnt = 0;
        repeat (250) begin
            @(negedge clk);
            if (rd_req) cnt++;
        end
        chk("disabled_no_req", cnt, 0);
        chk("ovr_none", ovr, 0);

        w = 0;
        while (!dut2_done && w < 6000) begin
            @(negedge clk);
            w++;
        end
        chk("dut2_complete", int'(dut2_done), 1);
        chk("scoreboard_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
